// File: rtl/rf_pkg.sv
// Shared constants and address-width helper for the parameterised register file.
package rf_pkg;
    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_NUM_REG   = 4;

    // A single-register address still needs one bit, hence the floor of 1.
    function automatic int calc_aw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: register mux, pending-based ready, write forwarding.
module rf_read_port import rf_pkg::*; #(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_REG   = DEF_NUM_REG,
    parameter int BYPASS    = 1,
    parameter int ZERO_R0   = 0,
    parameter int AW        = calc_aw(NUM_REG)
) (
    input  logic [AW-1:0]                     addr_i,
    input  logic [NUM_REG-1:0][WORD_SIZE-1:0] regs_i,
    input  logic [NUM_REG-1:0]                pend_i,
    input  logic                              wr_act_i,
    input  logic [AW-1:0]                     wr_addr_i,
    input  logic [WORD_SIZE-1:0]              wr_data_i,
    output logic [WORD_SIZE-1:0]              data_o,
    output logic                              ready_o
);
    always_comb begin
        // Out-of-range addresses fall through with zero data and ready set.
        data_o  = '0;
        ready_o = 1'b1;
        for (int r = 0; r < NUM_REG; r++) begin
            if (int'(addr_i) == r) begin
                data_o  = regs_i[r];
                ready_o = !pend_i[r];
            end
        end
        if (ZERO_R0 != 0 && addr_i == '0) begin
            data_o  = '0;
            ready_o = 1'b1;
        end
        // wr_act_i already excludes ignored writes, so forwarding never leaks them.
        if (BYPASS != 0 && wr_act_i && wr_addr_i == addr_i) begin
            data_o  = wr_data_i;
            ready_o = 1'b1;
        end
    end
endmodule

// File: rtl/param_rf.sv
// Parameterised register file with per-register pending (scoreboard) bits.
module param_rf import rf_pkg::*; #(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int NUM_REG   = DEF_NUM_REG,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_R0   = 0,
    localparam int AW       = calc_aw(NUM_REG)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD*AW-1:0]        rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0] rd_data,
    output logic [NUM_RD-1:0]           rd_ready,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WORD_SIZE-1:0]        wr_data,
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_addr,
    output logic                        rsv_ok,
    output logic [NUM_REG-1:0]          pend
);
    logic [NUM_REG-1:0][WORD_SIZE-1:0] regs_q, regs_d;
    logic [NUM_REG-1:0]                pend_q, pend_d;
    logic                              wr_act, rsv_in, rsv_free, rsv_set;

    assign wr_act = wr_en && (int'(wr_addr) < NUM_REG) && !(ZERO_R0 != 0 && wr_addr == '0);
    assign rsv_in = int'(rsv_addr) < NUM_REG;

    always_comb begin
        rsv_free = 1'b0;
        for (int r = 0; r < NUM_REG; r++)
            if (int'(rsv_addr) == r) rsv_free = !pend_q[r];
    end

    // A register being written this cycle is about to be released, so it counts as free.
    assign rsv_ok  = rsv_en && rsv_in && (rsv_free || (wr_en && wr_addr == rsv_addr));
    assign rsv_set = rsv_ok && !(ZERO_R0 != 0 && rsv_addr == '0);

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int r = 0; r < NUM_REG; r++) begin
            if (wr_act && int'(wr_addr) == r) begin
                regs_d[r] = wr_data;
                pend_d[r] = 1'b0;
            end
            // Reservation is applied after the write so it wins on a collision.
            if (rsv_set && int'(rsv_addr) == r) pend_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_read_port #(
            .WORD_SIZE(WORD_SIZE),
            .NUM_REG  (NUM_REG),
            .BYPASS   (BYPASS),
            .ZERO_R0  (ZERO_R0),
            .AW       (AW)
        ) u_rp (
            .addr_i   (rd_addr[i*AW +: AW]),
            .regs_i   (regs_q),
            .pend_i   (pend_q),
            .wr_act_i (wr_act),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .data_o   (rd_data[i*WORD_SIZE +: WORD_SIZE]),
            .ready_o  (rd_ready[i])
        );
    end
endmodule

// File: tb/tb_param_rf.sv
// Scoreboard bench for param_rf: two configurations checked against an abstract model.
module tb_param_rf;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: defaults (4 regs, 2 read ports, bypass on, r0 writable)
    logic        a_reset, a_wr_en, a_rsv_en, a_rsv_ok;
    logic [3:0]  a_rd_addr;
    logic [31:0] a_rd_data;
    logic [1:0]  a_rd_ready, a_wr_addr, a_rsv_addr;
    logic [15:0] a_wr_data;
    logic [3:0]  a_pend;

    // DUT B: 6 regs, 3 read ports, bypass off, r0 hardwired to zero
    logic        b_reset, b_wr_en, b_rsv_en, b_rsv_ok;
    logic [8:0]  b_rd_addr;
    logic [47:0] b_rd_data;
    logic [2:0]  b_rd_ready, b_wr_addr, b_rsv_addr;
    logic [15:0] b_wr_data;
    logic [5:0]  b_pend;

    param_rf #(.WORD_SIZE(16), .NUM_REG(4), .NUM_RD(2), .BYPASS(1), .ZERO_R0(0)) dut_a (
        .clk(clk), .reset(a_reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_ready(a_rd_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .rsv_ok(a_rsv_ok), .pend(a_pend));

    param_rf #(.WORD_SIZE(16), .NUM_REG(6), .NUM_RD(3), .BYPASS(0), .ZERO_R0(1)) dut_b (
        .clk(clk), .reset(b_reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_ready(b_rd_ready), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .rsv_ok(b_rsv_ok), .pend(b_pend));

    int NREG[2] = '{4, 6};
    int NRD[2]  = '{2, 3};
    bit BYP[2]  = '{1'b1, 1'b0};
    bit Z0[2]   = '{1'b0, 1'b1};

    // Architectural model: register contents and pending flags per DUT
    logic [15:0] m_regs[2][8];
    bit          m_pend[2][8];

    typedef struct {
        int          d;
        logic [47:0] data;
        logic [2:0]  rdy;
        logic        ok;
        logic [7:0]  pend;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [16:0] rexp(int d, int a, bit we, int wa, logic [15:0] wd);
        if (a >= NREG[d] || (Z0[d] && a == 0)) return {1'b1, 16'h0000};
        if (BYP[d] && we && wa == a) return {1'b1, wd};
        return {~m_pend[d][a], m_regs[d][a]};
    endfunction

    task automatic cycle(input int d, input bit rst, input bit we, input int wa,
                         input logic [15:0] wd, input bit re, input int ra,
                         input int r0, input int r1, input int r2);
        exp_t e;
        int   rda[3];
        logic [16:0] rv;
        rda = '{r0, r1, r2};
        a_reset = 1'b0; a_wr_en = 1'b0; a_rsv_en = 1'b0;
        b_reset = 1'b0; b_wr_en = 1'b0; b_rsv_en = 1'b0;
        if (d == 0) begin
            a_reset = rst; a_wr_en = we; a_wr_addr = wa[1:0]; a_wr_data = wd;
            a_rsv_en = re; a_rsv_addr = ra[1:0]; a_rd_addr = {r1[1:0], r0[1:0]};
        end else begin
            b_reset = rst; b_wr_en = we; b_wr_addr = wa[2:0]; b_wr_data = wd;
            b_rsv_en = re; b_rsv_addr = ra[2:0]; b_rd_addr = {r2[2:0], r1[2:0], r0[2:0]};
        end
        e.d = d; e.data = '0; e.rdy = '0; e.pend = '0;
        for (int p = 0; p < NRD[d]; p++) begin
            rv = rexp(d, rda[p], we, wa, wd);
            e.data[p*16 +: 16] = rv[15:0];
            e.rdy[p] = rv[16];
        end
        e.ok = re && ra < NREG[d] && (!m_pend[d][ra] || (we && wa == ra));
        for (int r = 0; r < NREG[d]; r++) e.pend[r] = m_pend[d][r];
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 8; r++) begin m_regs[d][r] = '0; m_pend[d][r] = 1'b0; end
        end else begin
            if (we && wa < NREG[d] && !(Z0[d] && wa == 0)) begin
                m_regs[d][wa] = wd; m_pend[d][wa] = 1'b0;
            end
            if (e.ok && !(Z0[d] && ra == 0)) m_pend[d][ra] = 1'b1;
        end
        #1;
    endtask

    task automatic check(input string name, input int d, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.d == 0) begin
                    check("rd_data",  0, {16'h0, a_rd_data}, e.data);
                    check("rd_ready", 0, {46'h0, a_rd_ready}, {45'h0, e.rdy});
                    check("rsv_ok",   0, {47'h0, a_rsv_ok}, {47'h0, e.ok});
                    check("pend",     0, {44'h0, a_pend}, {40'h0, e.pend});
                end else begin
                    check("rd_data",  1, b_rd_data, e.data);
                    check("rd_ready", 1, {45'h0, b_rd_ready}, {45'h0, e.rdy});
                    check("rsv_ok",   1, {47'h0, b_rsv_ok}, {47'h0, e.ok});
                    check("pend",     1, {42'h0, b_pend}, {40'h0, e.pend});
                end
            end
        end
    end

    initial begin
        int d, wa, ra, wait_cnt;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 8; r++) begin m_regs[k][r] = '0; m_pend[k][r] = 1'b0; end
        a_reset = 1'b1; a_wr_en = 1'b0; a_rsv_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_rsv_addr = '0; a_rd_addr = '0;
        b_reset = 1'b1; b_wr_en = 1'b0; b_rsv_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_rsv_addr = '0; b_rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;

        // DUT A directed
        cycle(0, 0, 1, 2, 16'h5555, 0, 0, 2, 0, 0);
        cycle(0, 1, 1, 2, 16'h1234, 0, 0, 2, 2, 0);   // reset beats write; bypass still visible
        cycle(0, 0, 0, 0, 16'h0000, 0, 0, 2, 2, 0);
        cycle(0, 0, 1, 1, 16'hBEEF, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 0, 16'h0000, 1, 3, 3, 1, 0);
        cycle(0, 0, 0, 0, 16'h0000, 1, 3, 3, 3, 0);   // second reserve refused
        cycle(0, 0, 1, 3, 16'h00A5, 0, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 16'h0000, 0, 0, 3, 3, 0);
        cycle(0, 0, 0, 0, 16'h0000, 1, 2, 2, 0, 0);
        cycle(0, 0, 1, 2, 16'h0F0F, 1, 2, 2, 2, 0);   // write + reserve collision
        cycle(0, 0, 0, 0, 16'h0000, 0, 0, 2, 2, 0);

        // DUT B directed
        cycle(1, 0, 1, 1, 16'hAAAA, 0, 0, 1, 1, 0);   // no forwarding
        cycle(1, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 1);
        cycle(1, 0, 1, 0, 16'hFFFF, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
        cycle(1, 0, 1, 7, 16'h1357, 1, 7, 7, 6, 5);
        cycle(1, 0, 0, 0, 16'h0000, 0, 0, 5, 6, 7);

        for (int i = 0; i < 600; i++) begin
            d  = i % 2;
            wa = (d == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7);
            ra = (d == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) ra = wa;
            cycle(d, ($urandom_range(0, 39) == 0), $urandom_range(0, 1), wa,
                  16'($urandom), $urandom_range(0, 1), ra,
                  (d == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7),
                  (d == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7),
                  $urandom_range(0, 7));
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 5) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_rf.md
PARAM_RF -- requirements
Module: param_rf

Interface
REQ-001 Parameter WORD_SIZE, default 16: data width in bits.
REQ-002 Parameter NUM_REG, default 4: register count, range 2..64.
REQ-003 Parameter NUM_RD, default 2: read port count, range 1..4.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-005 Parameter ZERO_R0, default 0: 1 = register 0 hardwired to zero.
REQ-006 Derived AW = max(1, clog2(NUM_REG)): address width.
REQ-007 clk  in  1  single clock; all state updates on posedge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-010 rd_data  out  NUM_RD*WORD_SIZE  read data, combinational, same slicing as rd_addr.
REQ-011 rd_ready  out  NUM_RD  per-port flag: data is architecturally valid, i.e. not pending or bypassed.
REQ-012 wr_en  in  1  write strobe.
REQ-013 wr_addr  in  AW  write address.
REQ-014 wr_data  in  WORD_SIZE  write data.
REQ-015 rsv_en  in  1  reservation request: a producer claims the destination register.
REQ-016 rsv_addr  in  AW  register to reserve.
REQ-017 rsv_ok  out  1  combinational grant for the current rsv_en.
REQ-018 pend  out  NUM_REG  pending bit per register (registered state).

Function
REQ-019 Storage: NUM_REG x WORD_SIZE registers plus NUM_REG pending bits; no other state.
REQ-020 Read: rd_data[i] = regs[rd_addr[i]] combinationally, zero-cycle latency.
REQ-021 Read ready: rd_ready[i] = !pend[rd_addr[i]].
REQ-022 Bypass (BYPASS=1, wr_en=1, wr_addr==rd_addr[i]): rd_data[i] = wr_data and rd_ready[i] = 1, same cycle.
REQ-023 Write: at posedge with wr_en=1, regs[wr_addr] <= wr_data and pend[wr_addr] <= 0.
REQ-024 A write to a non-pending register is legal; data is stored.
REQ-025 Reservation grant: rsv_ok = rsv_en & !pend[rsv_addr].
REQ-026 Exception to REQ-025: a register being written this cycle counts as free, so rsv_ok = 1.
REQ-027 Granted reservation: pend[rsv_addr] <= 1 at posedge.
REQ-028 Refused reservation (rsv_ok=0): no state change; requester retries.
REQ-029 Same address written and reserved in one cycle: data is stored AND pend ends at 1 (reservation wins).
REQ-030 ZERO_R0=1, register 0: reads return 0; rd_ready = 1; writes ignored; reservations granted but pend[0] stays 0.
REQ-031 Addresses >= NUM_REG: writes and reservations ignored; rsv_ok = 0; reads return 0 with rd_ready = 1.
REQ-032 Any number of read ports may target the same address; each returns identical data.
REQ-033 At most one write and one reservation per cycle; no arbitration needed.

Reset
REQ-034 When reset=1 at posedge: all regs <= 0 and all pend <= 0.
REQ-035 Reset overrides wr_en and rsv_en in the same cycle; in-flight reservations are discarded.
REQ-036 During reset, combinational outputs follow current state; bypass remains active.

Structure
REQ-037 Shared package rf_pkg holds the default WORD_SIZE and NUM_REG constants and the AW derivation function.
REQ-038 One sub-module, rf_read_port: one address in, data/ready out, bypass logic included; instantiated NUM_RD times via generate.
REQ-039 Flop-based storage; no memory macro.

Verification
REQ-040 Reset: wr_en=1 wr_addr=2 wr_data=16'h1234 with reset=1 -> after edge reg2=0, pend=4'b0000.
REQ-041 Bypass: write 16'hBEEF to r1 while rd_addr port0=1 -> same cycle rd_data0=16'hBEEF, rd_ready0=1; BYPASS=0 shows old value.
REQ-042 Scoreboard: reserve r3 (rsv_ok=1) -> pend=4'b1000, rd_ready=0 on port reading r3; second reserve of r3 -> rsv_ok=0.
REQ-043 Clearing write: write 16'h00A5 to r3 -> pend[3]=0 and a read returns 16'h00A5 with rd_ready=1.
REQ-044 Collision: r2 pending, write 16'h0F0F to r2 and reserve r2 in the same cycle -> rsv_ok=1, reg2=16'h0F0F, pend[2]=1.
REQ-045 ZERO_R0=1, NUM_REG=6: write r0 = 16'hFFFF -> read 0 with rd_ready=1; write addr 7 -> no state change, rsv_ok=0.
